// File: rtl/router_pkg.sv
// Shared defaults and helpers for the parametrised router synchroniser.
package router_pkg;

    localparam int unsigned NUM_PORTS_DEF = 3;
    localparam int unsigned ADDR_W_DEF    = 2;
    localparam int unsigned TMR_W_DEF     = 5;

    // Widest port count supported; the decode helper works at this width.
    localparam int unsigned MAX_PORTS = 8;

    // One-hot decode of addr; all-zero when addr falls outside 0..n-1.
    function automatic logic [MAX_PORTS-1:0] onehot(input int unsigned addr,
                                                    input int unsigned n);
        logic [MAX_PORTS-1:0] res;
        res = '0;
        if (addr < n && addr < MAX_PORTS) begin
            res = MAX_PORTS'(1) << addr;
        end
        return res;
    endfunction

endpackage

// File: rtl/router_sync_n_if.sv
// Handshake/bus bundle between router FSM, output FIFOs and router_sync_n.
interface router_sync_n_if #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned ADDR_W    = 2,
    parameter int unsigned TMR_W     = 5
) ();

    logic                 detect_addr;
    logic [ADDR_W-1:0]    din;
    logic                 write_enb_reg;
    logic [TMR_W-1:0]     cfg_timeout;
    logic [NUM_PORTS-1:0] re;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] full;

    logic [NUM_PORTS-1:0] we;
    logic                 fifo_full;
    logic [NUM_PORTS-1:0] valid_out;
    logic [NUM_PORTS-1:0] soft_rst;
    logic                 addr_err;

    // Driver side: router FSM, FIFOs and configuration.
    modport master (
        output detect_addr, din, write_enb_reg, cfg_timeout, re, empty, full,
        input  we, fifo_full, valid_out, soft_rst, addr_err
    );

    // Synchroniser side.
    modport slave (
        input  detect_addr, din, write_enb_reg, cfg_timeout, re, empty, full,
        output we, fifo_full, valid_out, soft_rst, addr_err
    );

endinterface

// File: rtl/router_port_timer.sv
// Per-port read-stall timer: pulses soft_rst for one cycle after cfg_timeout
// consecutive cycles in which the FIFO holds data but nobody reads it.
module router_port_timer #(
    parameter int unsigned TMR_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             valid,
    input  logic             re,
    input  logic [TMR_W-1:0] cfg_timeout,
    output logic             soft_rst
);

    logic [TMR_W-1:0] cnt_q, cnt_d;
    logic             soft_rst_q, soft_rst_d;

    // Next-state: priority chain of restart, disable, expiry and count.
    always_comb begin
        cnt_d      = cnt_q;
        soft_rst_d = 1'b0;
        if (!valid || re) begin
            cnt_d = '0;
        end else if (cfg_timeout == '0) begin
            cnt_d = '0;
        end else if (soft_rst_q) begin
            // Cycle after a pulse is spent at zero, so repeats are cfg+1 apart.
            cnt_d = '0;
        end else if (cnt_q >= cfg_timeout - TMR_W'(1)) begin
            // >= rather than == so a lowered cfg_timeout fires at once.
            soft_rst_d = 1'b1;
            cnt_d      = '0;
        end else begin
            cnt_d = cnt_q + TMR_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q      <= '0;
            soft_rst_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            soft_rst_q <= soft_rst_d;
        end
    end

    assign soft_rst = soft_rst_q;

endmodule

// File: rtl/router_sync_n.sv
// N-port router synchroniser: latches the destination address, decodes FIFO
// write enables, muxes back the addressed full flag and runs per-port
// read-stall timers.
module router_sync_n
    import router_pkg::*;
#(
    parameter int unsigned NUM_PORTS = NUM_PORTS_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned TMR_W     = TMR_W_DEF
) (
    input logic            clk,
    input logic            rstn,
    router_sync_n_if.slave bus
);

    logic [ADDR_W-1:0]    int_addr_q, int_addr_d;
    logic                 addr_err_q, addr_err_d;
    logic [MAX_PORTS-1:0] addr_dec;
    logic [NUM_PORTS-1:0] port_sel;
    logic [NUM_PORTS-1:0] soft_rst;

    // Address latch next-state: capture din and its range check on detect.
    always_comb begin
        int_addr_d = int_addr_q;
        addr_err_d = addr_err_q;
        if (bus.detect_addr) begin
            int_addr_d = bus.din;
            addr_err_d = (32'(bus.din) >= NUM_PORTS);
        end
    end

    // Address latch state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            int_addr_q <= '0;
            addr_err_q <= 1'b0;
        end else begin
            int_addr_q <= int_addr_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Decode from the registered address; a bad address selects no port.
    always_comb begin
        addr_dec = onehot(32'(int_addr_q), NUM_PORTS);
        port_sel = addr_err_q ? '0 : addr_dec[NUM_PORTS-1:0];
    end

    // Combinational outputs toward the FIFOs and the FSM.
    always_comb begin
        bus.we        = bus.write_enb_reg ? port_sel : '0;
        bus.fifo_full = |(bus.full & port_sel);
        bus.valid_out = ~bus.empty;
        bus.soft_rst  = soft_rst;
        bus.addr_err  = addr_err_q;
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_timer
        router_port_timer #(
            .TMR_W (TMR_W)
        ) u_timer (
            .clk         (clk),
            .rstn        (rstn),
            .valid       (bus.valid_out[g]),
            .re          (bus.re[g]),
            .cfg_timeout (bus.cfg_timeout),
            .soft_rst    (soft_rst[g])
        );
    end

endmodule

// File: tb/tb_router_sync_n.sv
// Bench for router_sync_n: decode table on a 3-port instance, timer scenarios
// on a 4-port instance with a scoreboard of expected soft_rst pulses.
module tb_router_sync_n;

    logic clk;
    logic rstn;

    router_sync_n_if #(.NUM_PORTS(3), .ADDR_W(2), .TMR_W(5)) if3 ();
    router_sync_n_if #(.NUM_PORTS(4), .ADDR_W(2), .TMR_W(5)) if4 ();

    router_sync_n #(
        .NUM_PORTS (3),
        .ADDR_W    (2),
        .TMR_W     (5)
    ) u_dut3 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if3)
    );

    router_sync_n #(
        .NUM_PORTS (4),
        .ADDR_W    (2),
        .TMR_W     (5)
    ) u_dut4 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int         cyc;
        logic [3:0] mask;
    } exp_t;
    exp_t sbq[$];
    exp_t e;

    typedef struct {
        logic       det;
        logic [1:0] din;
        logic       wenb;
        logic [2:0] full;
        logic [2:0] empty;
        logic [2:0] exp_we;
        logic       exp_ff;
        logic [2:0] exp_valid;
        logic       exp_err;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pulse monitor: each edge, match soft_rst against the queued expectation.
    always @(posedge clk) begin
        #1;
        cyc++;
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            e = sbq.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missed_pulse: soft_rst %b never seen at cycle %0d", e.mask, e.cyc);
        end
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            e = sbq.pop_front();
            chk("soft_rst_pulse", 32'(if4.soft_rst), 32'(e.mask));
        end else if (if4.soft_rst != '0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_pulse: soft_rst=%b at cycle %0d, expected 0000",
                     if4.soft_rst, cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int r0;

        //           det  din    wenb  full    empty   we      ff    valid   err
        tbl[0] = '{1'b0, 2'd0, 1'b1, 3'b001, 3'b111, 3'b001, 1'b1, 3'b000, 1'b0};
        tbl[1] = '{1'b1, 2'd2, 1'b0, 3'b000, 3'b010, 3'b000, 1'b0, 3'b101, 1'b0};
        tbl[2] = '{1'b0, 2'd0, 1'b1, 3'b100, 3'b000, 3'b100, 1'b1, 3'b111, 1'b0};
        tbl[3] = '{1'b0, 2'd0, 1'b1, 3'b011, 3'b000, 3'b100, 1'b0, 3'b111, 1'b0};
        tbl[4] = '{1'b1, 2'd1, 1'b1, 3'b100, 3'b110, 3'b100, 1'b1, 3'b001, 1'b0};
        tbl[5] = '{1'b0, 2'd0, 1'b1, 3'b010, 3'b000, 3'b010, 1'b1, 3'b111, 1'b0};
        tbl[6] = '{1'b1, 2'd3, 1'b0, 3'b111, 3'b011, 3'b000, 1'b1, 3'b100, 1'b1};
        tbl[7] = '{1'b0, 2'd0, 1'b1, 3'b111, 3'b000, 3'b000, 1'b0, 3'b111, 1'b1};
        tbl[8] = '{1'b1, 2'd0, 1'b1, 3'b001, 3'b000, 3'b000, 1'b0, 3'b111, 1'b0};
        tbl[9] = '{1'b0, 2'd0, 1'b1, 3'b001, 3'b101, 3'b001, 1'b1, 3'b010, 1'b0};

        rstn               = 1'b0;
        if3.detect_addr    = 1'b0;
        if3.din            = '0;
        if3.write_enb_reg  = 1'b0;
        if3.cfg_timeout    = '0;
        if3.re             = '0;
        if3.empty          = '1;
        if3.full           = '0;
        if4.detect_addr    = 1'b0;
        if4.din            = '0;
        if4.write_enb_reg  = 1'b0;
        if4.cfg_timeout    = 5'd30;
        if4.re             = '0;
        if4.empty          = '1;
        if4.full           = '0;

        #3;
        chk("rst_soft_rst", 32'(if4.soft_rst), 32'h0);
        chk("rst_addr_err", 32'(if4.addr_err), 32'h0);
        chk("rst_we", 32'(if4.we), 32'h0);
        chk("rst_valid_out", 32'(if4.valid_out), 32'h0);

        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Decode table: comb outputs before the edge, addr_err after it.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if3.detect_addr   = tbl[i].det;
            if3.din           = tbl[i].din;
            if3.write_enb_reg = tbl[i].wenb;
            if3.full          = tbl[i].full;
            if3.empty         = tbl[i].empty;
            #1;
            chk($sformatf("we[%0d]", i), 32'(if3.we), 32'(tbl[i].exp_we));
            chk($sformatf("fifo_full[%0d]", i), 32'(if3.fifo_full), 32'(tbl[i].exp_ff));
            chk($sformatf("valid_out[%0d]", i), 32'(if3.valid_out), 32'(tbl[i].exp_valid));
            @(posedge clk);
            #2;
            chk($sformatf("addr_err[%0d]", i), 32'(if3.addr_err), 32'(tbl[i].exp_err));
        end
        @(negedge clk);
        if3.detect_addr   = 1'b0;
        if3.write_enb_reg = 1'b0;
        if3.empty         = '1;

        // Timeout at 30 with a repeat 31 cycles later.
        @(negedge clk);
        n0 = cyc;
        if4.empty[0] = 1'b0;
        sbq.push_back('{n0 + 30, 4'b0001});
        sbq.push_back('{n0 + 61, 4'b0001});
        repeat (62) @(negedge clk);
        if4.empty = '1;

        // A single read after 29 stalls restarts the window.
        @(negedge clk);
        n0 = cyc;
        if4.empty[0] = 1'b0;
        repeat (29) @(negedge clk);
        if4.re[0] = 1'b1;
        @(negedge clk);
        if4.re[0] = 1'b0;
        sbq.push_back('{n0 + 60, 4'b0001});
        repeat (31) @(negedge clk);
        if4.empty = '1;

        // cfg_timeout = 0 disables the timer.
        @(negedge clk);
        if4.cfg_timeout = '0;
        if4.empty[0]    = 1'b0;
        repeat (70) @(negedge clk);
        if4.empty = '1;

        // Lowering cfg below the running count fires on the next edge.
        @(negedge clk);
        n0 = cyc;
        if4.cfg_timeout = 5'd20;
        if4.empty[0]    = 1'b0;
        repeat (15) @(negedge clk);
        if4.cfg_timeout = 5'd10;
        sbq.push_back('{n0 + 16, 4'b0001});
        repeat (2) @(negedge clk);
        if4.empty = '1;

        // Ports 1 and 3 stall together; port 0 reads every cycle.
        @(negedge clk);
        n0 = cyc;
        if4.cfg_timeout = 5'd5;
        if4.empty       = 4'b0100;
        if4.re          = 4'b0001;
        sbq.push_back('{n0 + 5, 4'b1010});
        sbq.push_back('{n0 + 11, 4'b1010});
        #1;
        chk("par_valid_out", 32'(if4.valid_out), 32'hb);
        repeat (12) @(negedge clk);
        if4.empty = '1;
        if4.re    = '0;

        // Async reset mid-count clears address, error flag and timer.
        @(negedge clk);
        if4.cfg_timeout   = 5'd30;
        if4.detect_addr   = 1'b1;
        if4.din           = 2'd3;
        if4.write_enb_reg = 1'b1;
        if4.empty[2]      = 1'b0;
        if3.detect_addr   = 1'b1;
        if3.din           = 2'd3;
        @(negedge clk);
        if4.detect_addr = 1'b0;
        if3.detect_addr = 1'b0;
        repeat (11) @(negedge clk);
        chk("pre_rst_addr_err", 32'(if3.addr_err), 32'h1);
        chk("pre_rst_we", 32'(if4.we), 32'h8);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_addr_err", 32'(if3.addr_err), 32'h0);
        chk("midrst_we", 32'(if4.we), 32'h1);
        chk("midrst_soft_rst", 32'(if4.soft_rst), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        r0 = cyc;
        sbq.push_back('{r0 + 30, 4'b0100});
        repeat (31) @(negedge clk);
        if4.empty         = '1;
        if4.write_enb_reg = 1'b0;

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/router_sync_n.md
Name: router_sync_n

Overview:
- Parametrised successor to the 1x3 router synchroniser. Sits between the router FSM/register block and NUM_PORTS output FIFOs.
- Latches the destination address and decodes it into one-hot FIFO write enables. Muxes back the selected FIFO's full flag.
- Generates valid_out per port and a runtime-programmable read-timeout soft reset per port.
- Adds out-of-range address detection and timeout disable, which the fixed 3-port block lacks.

Parameters:
- NUM_PORTS, 3, number of output ports/FIFOs (2..8).
- ADDR_W, 2, width of din address field; must be >= clog2(NUM_PORTS).
- TMR_W, 5, width of per-port timeout counter and cfg_timeout.

Ports:
- clk  in  1  clock, all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- detect_addr  in  1  capture din as destination address this cycle.
- din  in  ADDR_W  destination address (header low bits).
- write_enb_reg  in  1  FSM request to write current byte to selected FIFO.
- cfg_timeout  in  TMR_W  stall cycles before soft reset; 0 = timeout disabled.
- re  in  NUM_PORTS  per-port read enable from downstream.
- empty  in  NUM_PORTS  per-port FIFO empty.
- full  in  NUM_PORTS  per-port FIFO full.
- we  out  NUM_PORTS  one-hot FIFO write enable (combinational).
- fifo_full  out  1  full flag of addressed FIFO (combinational).
- valid_out  out  NUM_PORTS  ~empty per port (combinational).
- soft_rst  out  NUM_PORTS  one-cycle registered soft-reset pulse per port.
- addr_err  out  1  registered; latched address is >= NUM_PORTS.

Behaviour:
- Reset (async, rstn=0): int_addr=0, addr_err=0, all timer counts=0, soft_rst=0. Outputs update immediately, not at the next edge.
- Address latch: on a clk edge with detect_addr=1:
  - int_addr <= din.
  - addr_err <= (din >= NUM_PORTS).
  - Otherwise both hold.
- we: zero unless write_enb_reg=1 and addr_err=0; then we = 1 << int_addr.
  - Decode uses the registered int_addr. If detect_addr and write_enb_reg are both high in one cycle, we targets the previous address.
- fifo_full = full[int_addr] when addr_err=0, else 0.
- valid_out[i] = ~empty[i]. No latency.
- Per-port timer i, evaluated each edge in priority order:
  1. empty[i]=1 or re[i]=1 -> cnt<=0, soft_rst[i]<=0 (any read restarts the window).
  2. cfg_timeout=0 -> cnt<=0, soft_rst[i]<=0.
  3. cnt >= cfg_timeout-1 -> soft_rst[i]<=1, cnt<=0. The >= compare covers cfg_timeout lowered mid-count, with no wrap.
  4. Otherwise cnt<=cnt+1, soft_rst[i]<=0.
- Timeout timing: soft_rst[i] rises at the edge ending the cfg_timeout-th consecutive stalled cycle (valid, no read). It is high for exactly one cycle.
- After a timeout, if the FIFO is still non-empty, counting restarts from 0. Repeat pulses are spaced cfg_timeout+1 cycles apart (one cycle spent at cnt=0 after the pulse).
- Ports are fully independent; simultaneous timeouts on several ports are legal.
- A reset asserted mid-count clears the count. There is no partial carry-over.
- Counter width rule: cfg_timeout maximum is 2^TMR_W-1. cnt never exceeds cfg_timeout-1.

Decomposition:
- router_pkg: NUM_PORTS_DEF, ADDR_W_DEF, TMR_W_DEF localparams and a function onehot(addr, n).
- Sub-module router_port_timer (ports: clk, rstn, valid, re, cfg_timeout, soft_rst). Instantiated NUM_PORTS times via generate.
- Address latch and decode stay in the top.

Test Plan:
- Reset/idle: rstn low mid-run with cnt=12 -> all outputs 0 immediately; after release, timer restarts at 0.
- Decode: detect_addr with din=2, then write_enb_reg=1 -> we=3'b100, fifo_full follows full[2]; din=3 (NUM_PORTS=3) -> addr_err=1, we=0, fifo_full=0.
- Timeout: cfg_timeout=30, empty[0]=0, re[0]=0 -> soft_rst[0] high exactly one cycle at the 30th edge; next pulse 31 cycles later.
- Read restarts: stall 29 cycles, re[0]=1 for one cycle, stall again -> no pulse until 30 further stalled cycles.
- Disable/shrink: cfg_timeout=0 with stalled port -> no pulse ever. Stall with cfg=20 to cnt=15, then set cfg=10 -> pulse on the next edge.
- Parallel: NUM_PORTS=4, ports 1 and 3 stall together at cfg=5 -> simultaneous soft_rst=4'b1010. Port 0 reading continuously -> never pulses.
